addr_seq_ctrl: RTL and testbench

//  Controller that sequences the address register. Arbitrates instruction fetch (PC bus) and data

---
 rtl/addr_seq_pkg.sv | 25 ++
 rtl/addr_seq_if.sv | 35 +++
 rtl/addr_seq_wait_timer.sv | 30 +++
 rtl/addr_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_addr_seq_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/addr_seq_pkg.sv
// Shared encodings for the address-register sequencer: AR source selects,
// controller states and requester (owner) codes.
package addr_seq_pkg;

    // AR source select driven onto ar_sel.
    typedef enum logic [1:0] {
        AR_HOLD = 2'b00,
        AR_ALU  = 2'b01,
        AR_INC  = 2'b10,
        AR_PC   = 2'b11
    } ar_sel_e;

    // Controller states: IDLE arbitrates and loads AR, ACCESS runs the memory handshake.
    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    // Which requester owns the transaction in flight.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DP = 1'b1
    } owner_e;

endpackage

// File: rtl/addr_seq_if.sv
// Bundle of request, AR-control and memory-handshake signals around the
// address sequencer. The master side is the environment (control unit,
// address register and memory); the slave side is the sequencer itself.
interface addr_seq_if #(
    parameter int COUNT_W = 5
);
    logic               if_req;
    logic               if_ack;
    logic               dp_req;
    logic               dp_we;
    logic [COUNT_W-1:0] dp_count;
    logic               dp_ack;
    logic               dp_done;
    logic [1:0]         ar_sel;
    logic               ar_write;
    logic               ar_out_en;
    logic [1:0]         addr_lsb;
    logic               mem_req;
    logic               mem_we;
    logic               mem_rdy;
    logic               busy;
    logic               err;

    modport master (
        output if_req, dp_req, dp_we, dp_count, addr_lsb, mem_rdy,
        input  if_ack, dp_ack, dp_done, ar_sel, ar_write, ar_out_en,
               mem_req, mem_we, busy, err
    );

    modport slave (
        input  if_req, dp_req, dp_we, dp_count, addr_lsb, mem_rdy,
        output if_ack, dp_ack, dp_done, ar_sel, ar_write, ar_out_en,
               mem_req, mem_we, busy, err
    );
endinterface

// File: rtl/addr_seq_wait_timer.sv
// Memory wait-state timer: counts cycles with mem_rdy low inside one word
// access and flags expiry once WAIT_MAX cycles have been spent waiting.
module addr_seq_wait_timer #(
    parameter int WAIT_MAX = 15,
    parameter int WAIT_W   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [WAIT_W-1:0] count;

    assign expired = (count == WAIT_W'(WAIT_MAX));

    // Wait counter: clear wins, then count up and park at WAIT_MAX.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments keep every register updating from pre-edge values, avoiding simulation races.
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + WAIT_W'(1);
        end
    end

endmodule

// File: rtl/addr_seq_ctrl.sv
// Address-register sequencer. Arbitrates fetch (PC bus) against data (ALU
// bus) requests with alternating priority, loads AR, runs the memory
// handshake and steps block transfers through the AR incrementer.
// Optional build macro ALIGN_CHECK_EN: aborts any word whose AR bits [1:0]
// are non-zero instead of issuing the memory request.
module addr_seq_ctrl
    import addr_seq_pkg::*;
#(
    parameter int COUNT_W  = 5,
    parameter int WAIT_MAX = 15,
    parameter int WAIT_W   = 4
) (
    input logic      clk,
    input logic      rst_n,
    addr_seq_if.slave bus
);

    state_e             state,    state_n;
    owner_e             owner,    owner_n;
    logic               we_q,     we_n;
    logic [COUNT_W-1:0] word_cnt, word_cnt_n;
    logic               prio_if,  prio_if_n;
    logic               grant_dp;
    logic               tmr_clear;
    logic               tmr_en;
    logic               tmr_expired;
    logic               misaligned;

`ifdef ALIGN_CHECK_EN
    assign misaligned = (bus.addr_lsb != 2'b00);
`else
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^bus.addr_lsb;
    assign misaligned      = 1'b0;
`endif

    // Data wins unless fetch is also pending and fetch holds the priority token.
    assign grant_dp = bus.dp_req && !(bus.if_req && prio_if);

    addr_seq_wait_timer #(
        .WAIT_MAX (WAIT_MAX),
        .WAIT_W   (WAIT_W)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (tmr_clear),
        .enable  (tmr_en),
        .expired (tmr_expired)
    );

    // State register plus the transaction context latched at grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= OWN_IF;
            we_q     <= 1'b0;
            word_cnt <= '0;
            prio_if  <= 1'b0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            we_q     <= we_n;
            word_cnt <= word_cnt_n;
            prio_if  <= prio_if_n;
        end
    end

    // Next-state and output decode; grant only in IDLE, ack/done/err only in ACCESS.
    always_comb begin
        // NOTE: every output and next-state variable gets a default first, so no path can infer a latch.
        state_n       = state;
        owner_n       = owner;
        we_n          = we_q;
        word_cnt_n    = word_cnt;
        prio_if_n     = prio_if;
        tmr_clear     = 1'b1;
        tmr_en        = 1'b0;
        bus.ar_sel    = AR_HOLD;
        bus.ar_write  = 1'b0;
        bus.ar_out_en = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.busy      = 1'b0;
        bus.if_ack    = 1'b0;
        bus.dp_ack    = 1'b0;
        bus.dp_done   = 1'b0;
        bus.err       = 1'b0;

        case (state)
            IDLE: begin
                if (bus.dp_req || bus.if_req) begin
                    bus.ar_write = 1'b1;
                    bus.ar_sel   = grant_dp ? AR_ALU : AR_PC;
                    owner_n      = grant_dp ? OWN_DP : OWN_IF;
                    we_n         = grant_dp && bus.dp_we;
                    word_cnt_n   = grant_dp ? bus.dp_count : '0;
                    prio_if_n    = !prio_if;
                    state_n      = ACCESS;
                end
            end

            ACCESS: begin
                bus.busy      = 1'b1;
                bus.ar_out_en = 1'b1;
                bus.mem_req   = 1'b1;
                bus.mem_we    = we_q;
                tmr_clear     = 1'b0;
                if (misaligned) begin
                    bus.mem_req = 1'b0;
                    bus.mem_we  = 1'b0;
                    bus.err     = 1'b1;
                    tmr_clear   = 1'b1;
                    state_n     = IDLE;
                end else if (bus.mem_rdy) begin
                    tmr_clear = 1'b1;
                    if (owner == OWN_DP) begin
                        bus.dp_ack = 1'b1;
                    end else begin
                        bus.if_ack = 1'b1;
                    end
                    if (word_cnt != '0) begin
                        // More words: step AR by one word and keep the bus.
                        word_cnt_n   = word_cnt - COUNT_W'(1);
                        bus.ar_sel   = AR_INC;
                        bus.ar_write = 1'b1;
                    end else begin
                        bus.dp_done = (owner == OWN_DP);
                        state_n     = IDLE;
                    end
                end else if (tmr_expired) begin
                    bus.err   = 1'b1;
                    tmr_clear = 1'b1;
                    state_n   = IDLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end

            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_addr_seq_ctrl.sv
// Scoreboard bench for addr_seq_ctrl: scenario tasks drive requests and push
// expected ack/done/err events; a negedge monitor pops and compares them.
// Honours ALIGN_CHECK_EN in the alignment scenario.
module tb_addr_seq_ctrl;

    localparam int COUNT_W  = 5;
    localparam int WAIT_MAX = 15;
    localparam int WAIT_W   = 4;

    logic clk = 1'b0;
    logic rst_n;

    addr_seq_if #(.COUNT_W(COUNT_W)) bus ();

    addr_seq_ctrl #(
        .COUNT_W  (COUNT_W),
        .WAIT_MAX (WAIT_MAX),
        .WAIT_W   (WAIT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    logic [6:0] exp_q[$];
    logic       prio_model;
    logic [6:0] mon_obs;
    logic [6:0] mon_exp;

    // Event word: {err, dp_done, dp_ack, if_ack, ar_write, ar_sel}
    function automatic logic [6:0] ev(input logic e, input logic d, input logic a,
                                      input logic f, input logic w, input logic [1:0] s);
        return {e, d, a, f, w, s};
    endfunction

    function automatic logic [10:0] all_outs();
        return {bus.busy, bus.mem_req, bus.mem_we, bus.ar_out_en, bus.ar_write, bus.ar_sel,
                bus.if_ack, bus.dp_ack, bus.dp_done, bus.err};
    endfunction

    // Scoreboard monitor: every ack/err cycle must match the next expected event.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (bus.if_ack || bus.dp_ack || bus.err)) begin
            mon_obs = {bus.err, bus.dp_done, bus.dp_ack, bus.if_ack, bus.ar_write, bus.ar_sel};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got event %b, required none", mon_obs);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_obs !== mon_exp) begin
                    failures++;
                    $display("FAIL sb_event: got %b, required %b", mon_obs, mon_exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.if_req   = 1'b0;
        bus.dp_req   = 1'b0;
        bus.dp_we    = 1'b0;
        bus.dp_count = '0;
        bus.addr_lsb = 2'b00;
        bus.mem_rdy  = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        prio_model = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL %s_drained: got %0d pending events, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (all_outs() !== 11'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %b, required 0", all_outs());
        end
        step();
        rst_n      = 1'b1;
        prio_model = 1'b0;
    endtask

    task automatic test_single_write();
        bus.dp_req = 1'b1; bus.dp_we = 1'b1; bus.dp_count = '0; bus.mem_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.ar_sel, bus.ar_write, bus.busy, bus.mem_req} !== 5'b01100) begin
            failures++;
            $display("FAIL single_grant: got %b, required 01100",
                     {bus.ar_sel, bus.ar_write, bus.busy, bus.mem_req});
        end
        exp_q.push_back(ev(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00));
        prio_model = !prio_model;
        step();
        bus.dp_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.ar_out_en, bus.busy} !== 4'b1111) begin
            failures++;
            $display("FAIL single_access: got %b, required 1111",
                     {bus.mem_req, bus.mem_we, bus.ar_out_en, bus.busy});
        end
        step();
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.mem_req, bus.ar_write} !== 3'b000) begin
            failures++;
            $display("FAIL single_idle: got %b, required 000", {bus.busy, bus.mem_req, bus.ar_write});
        end
        step();
        check_drained("single");
    endtask

    task automatic test_burst();
        bus.dp_req = 1'b1; bus.dp_we = 1'b0; bus.dp_count = 5'd3; bus.mem_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.ar_sel, bus.ar_write} !== 3'b011) begin
            failures++;
            $display("FAIL burst_grant: got %b, required 011", {bus.ar_sel, bus.ar_write});
        end
        for (int i = 0; i < 3; i++) exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10));
        exp_q.push_back(ev(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00));
        prio_model = !prio_model;
        step();
        bus.dp_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.busy, bus.mem_req, bus.mem_we, bus.dp_ack} !== 4'b1101) begin
                failures++;
                $display("FAIL burst_word%0d: got %b, required 1101", i,
                         {bus.busy, bus.mem_req, bus.mem_we, bus.dp_ack});
            end
            step();
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL burst_idle: got busy=%b, required 0", bus.busy);
        end
        step();
        check_drained("burst");
    endtask

    task automatic test_reset_mid_burst();
        bus.dp_req = 1'b1; bus.dp_we = 1'b1; bus.dp_count = 5'd3; bus.mem_rdy = 1'b1;
        @(negedge clk);
        exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10));
        step();
        bus.dp_req = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        bus.mem_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (all_outs() !== 11'd0) begin
                failures++;
                $display("FAIL midreset_outputs%0d: got %b, required 0", i, all_outs());
            end
            step();
        end
        rst_n      = 1'b1;
        prio_model = 1'b0;
        check_drained("midreset");
        bus.if_req = 1'b1; bus.mem_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.ar_sel, bus.ar_write} !== 3'b111) begin
            failures++;
            $display("FAIL restart_grant: got %b, required 111", {bus.ar_sel, bus.ar_write});
        end
        exp_q.push_back(ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00));
        prio_model = !prio_model;
        step();
        bus.if_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.if_ack} !== 3'b101) begin
            failures++;
            $display("FAIL restart_access: got %b, required 101", {bus.mem_req, bus.mem_we, bus.if_ack});
        end
        step();
        step();
        check_drained("restart");
    endtask

    task automatic test_arbitration();
        logic exp_dp;
        apply_reset();
        bus.if_req = 1'b1; bus.dp_req = 1'b1; bus.dp_count = '0; bus.mem_rdy = 1'b1;
        for (int t = 0; t < 4; t++) begin
            exp_dp = !prio_model;
            @(negedge clk);
            checks++;
            if ({bus.busy, bus.ar_write, bus.ar_sel} !== {1'b0, 1'b1, exp_dp ? 2'b01 : 2'b11}) begin
                failures++;
                $display("FAIL arb_grant%0d: got %b, required %b", t,
                         {bus.busy, bus.ar_write, bus.ar_sel}, {1'b0, 1'b1, exp_dp ? 2'b01 : 2'b11});
            end
            exp_q.push_back(ev(1'b0, exp_dp, exp_dp, !exp_dp, 1'b0, 2'b00));
            prio_model = !prio_model;
            step();
            if (t == 3) begin
                bus.if_req = 1'b0;
                bus.dp_req = 1'b0;
            end
            @(negedge clk);
            checks++;
            if ({bus.busy, bus.if_ack, bus.dp_ack} !== {1'b1, !exp_dp, exp_dp}) begin
                failures++;
                $display("FAIL arb_ack%0d: got %b, required %b", t,
                         {bus.busy, bus.if_ack, bus.dp_ack}, {1'b1, !exp_dp, exp_dp});
            end
            step();
        end
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.ar_write} !== 2'b00) begin
            failures++;
            $display("FAIL arb_idle: got %b, required 00", {bus.busy, bus.ar_write});
        end
        step();
        check_drained("arb");
    endtask

    task automatic test_timeout();
        bus.if_req = 1'b1; bus.mem_rdy = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ar_sel !== 2'b11) begin
            failures++;
            $display("FAIL timeout_grant: got %b, required 11", bus.ar_sel);
        end
        exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
        prio_model = !prio_model;
        step();
        bus.if_req = 1'b0;
        for (int k = 1; k <= WAIT_MAX + 1; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.busy, bus.mem_req, bus.err, bus.if_ack} !== {1'b1, 1'b1, (k == WAIT_MAX + 1), 1'b0}) begin
                failures++;
                $display("FAIL timeout_cycle%0d: got %b, required %b", k,
                         {bus.busy, bus.mem_req, bus.err, bus.if_ack}, {1'b1, 1'b1, (k == WAIT_MAX + 1), 1'b0});
            end
            step();
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_idle: got busy=%b, required 0", bus.busy);
        end
        step();
        check_drained("timeout");
    endtask

    task automatic test_wait_boundary();
        bus.dp_req = 1'b1; bus.dp_we = 1'b1; bus.dp_count = 5'd1; bus.mem_rdy = 1'b0;
        @(negedge clk);
        exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10));
        exp_q.push_back(ev(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00));
        prio_model = !prio_model;
        step();
        bus.dp_req = 1'b0;
        for (int w = 0; w < 2; w++) begin
            repeat (WAIT_MAX) step();
            bus.mem_rdy = 1'b1;
            @(negedge clk);
            checks++;
            if ({bus.dp_ack, bus.err} !== 2'b10) begin
                failures++;
                $display("FAIL waitmax_word%0d: got %b, required 10", w, {bus.dp_ack, bus.err});
            end
            step();
            bus.mem_rdy = 1'b0;
        end
        step();
        check_drained("waitmax");
    endtask

    task automatic test_max_count();
        bus.dp_req = 1'b1; bus.dp_we = 1'b0; bus.dp_count = '1; bus.mem_rdy = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 31; i++) exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10));
        exp_q.push_back(ev(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00));
        prio_model = !prio_model;
        step();
        bus.dp_req = 1'b0;
        repeat (32) step();
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL maxcount_idle: got busy=%b, required 0", bus.busy);
        end
        step();
        check_drained("maxcount");
    endtask

    task automatic test_align();
        logic [3:0] exp_acc;
        bus.dp_req = 1'b1; bus.dp_we = 1'b1; bus.dp_count = '0; bus.mem_rdy = 1'b1;
        bus.addr_lsb = 2'b01;
        @(negedge clk);
`ifdef ALIGN_CHECK_EN
        exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
        exp_acc = 4'b0010;
`else
        exp_q.push_back(ev(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00));
        exp_acc = 4'b1101;
`endif
        prio_model = !prio_model;
        step();
        bus.dp_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.err, bus.dp_ack} !== exp_acc) begin
            failures++;
            $display("FAIL align_access: got %b, required %b",
                     {bus.mem_req, bus.mem_we, bus.err, bus.dp_ack}, exp_acc);
        end
        step();
        bus.addr_lsb = 2'b00;
        step();
        check_drained("align");
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got no finish by 50000ns, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_write();
        test_burst();
        test_reset_mid_burst();
        test_arbitration();
        test_timeout();
        test_wait_boundary();
        test_max_count();
        test_align();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
